spi_mul: RTL

SPI_MUL -- requirements
Module: spi_mul

---
 rtl/spi_mul_if.sv | 12 +
 rtl/spi_mul.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_mul_if.sv
// Serial link between the CPU SPI master and the spi_mul multiplier.
// The master drives cs_n/sck/mosi; the block returns miso and a busy flag.
interface spi_mul_if;
  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;
  logic busy;

  modport master (output cs_n, output sck, output mosi, input miso, input busy);
  modport slave  (input cs_n, input sck, input mosi, output miso, output busy);
endinterface

// File: rtl/spi_mul.sv
// SPI-attached shift-add multiplier: receives command and two operands,
// multiplies over WIDTH+1 cycles, then shifts the 2*WIDTH product out.
module spi_mul #(
  parameter int WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  spi_mul_if.slave    bus,
  output logic [2:0]  state_dbg
);

  // Handshake: cs_n low frames a transfer; master samples/drives on sck rise,
  // block shifts miso on sck fall; master waits for busy low before the
  // product phase; cs_n high at any point returns the block to idle.
  localparam int TOTAL = 8 + 2 * WIDTH;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, RX, CALC, TX, DONE} state_t;

  state_t                state;
  logic                  sck_q;
  logic                  cs_n_q;
  logic [CW-1:0]         cnt;
  logic [TOTAL-2:0]      in_sr;
  logic [PW-1:0]         mcand;
  logic [WIDTH-1:0]      mplier;
  logic [PW-1:0]         acc;
  logic                  neg;
  logic                  cmd_ok;
  logic [PW-2:0]         prod_sr;
  logic                  miso_r;
  logic                  busy_r;

  logic                  rise;
  logic                  fall;
  logic [TOTAL-1:0]      rx_next;
  logic [7:0]            cmd_in;
  logic [WIDTH-1:0]      a_in;
  logic [WIDTH-1:0]      b_in;
  logic                  signed_in;
  logic [WIDTH-1:0]      a_mag;
  logic [WIDTH-1:0]      b_mag;
  logic [PW-1:0]         result;

  assign rise = bus.sck & ~sck_q;
  assign fall = ~bus.sck & sck_q;

  // The final mosi bit is folded in combinationally so operands load on the
  // same edge that enters CALC.
  assign rx_next   = {in_sr, bus.mosi};
  assign cmd_in    = rx_next[TOTAL-1 -: 8];
  assign a_in      = rx_next[PW-1 -: WIDTH];
  assign b_in      = rx_next[WIDTH-1:0];
  assign signed_in = cmd_in[0];

  // Negating -2^(WIDTH-1) wraps to the same bit pattern, which read unsigned
  // is exactly the required magnitude.
  assign a_mag = (signed_in && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
  assign b_mag = (signed_in && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;

  assign result = !cmd_ok ? {PW{1'b1}} : (neg ? (~acc + PW'(1)) : acc);

  assign bus.miso  = miso_r;
  assign bus.busy  = busy_r;
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      cnt     <= '0;
      in_sr   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      cmd_ok  <= 1'b0;
      prod_sr <= '0;
      miso_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      sck_q  <= bus.sck;
      cs_n_q <= bus.cs_n;
      case (state)
        IDLE: begin
          miso_r <= 1'b0;
          busy_r <= 1'b0;
          if (cs_n_q && !bus.cs_n) begin
            state <= RX;
            cnt   <= '0;
          end
        end
        RX: begin
          if (bus.cs_n) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            miso_r <= 1'b0;
            cnt    <= '0;
          end else if (rise) begin
            in_sr <= rx_next[TOTAL-2:0];
            if (cnt == CW'(TOTAL - 1)) begin
              state  <= CALC;
              busy_r <= 1'b1;
              cnt    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              acc    <= '0;
              neg    <= signed_in & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
              cmd_ok <= (cmd_in[7:1] == 7'd0);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        CALC: begin
          if (bus.cs_n) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            miso_r <= 1'b0;
            cnt    <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            // Sign-fixup cycle: the product MSB is on miso before the first rise.
            state   <= TX;
            busy_r  <= 1'b0;
            miso_r  <= result[PW-1];
            prod_sr <= result[PW-2:0];
            cnt     <= '0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        TX: begin
          if (bus.cs_n) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            miso_r <= 1'b0;
            cnt    <= '0;
          end else begin
            if (fall) begin
              miso_r  <= prod_sr[PW-2];
              prod_sr <= {prod_sr[PW-3:0], 1'b0};
            end
            if (rise) begin
              if (cnt == CW'(PW - 1)) begin
                state  <= DONE;
                miso_r <= 1'b0;
                cnt    <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
        DONE: begin
          miso_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.cs_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
